// File: rtl/fp_div_pkg.sv
// Shared types and encoding helpers for the sequential FP divider and its rounding stage.
package fp_div_pkg;

    localparam int FP_MAX_W = 64;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_RND  = 2'd2,
        S_DONE = 2'd3
    } fp_div_state_t;

    typedef enum logic [1:0] {
        RM_RNE = 2'd0,
        RM_RTZ = 2'd1,
        RM_RUP = 2'd2,
        RM_RDN = 2'd3
    } fp_rm_t;

    typedef struct packed {
        logic invalid;
        logic div_by_zero;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    // Signed infinity for an (exp_w, man_w) format, right-aligned in FP_MAX_W bits.
    function automatic logic [FP_MAX_W-1:0] fp_inf(input int exp_w, input int man_w, input logic sign);
        logic [FP_MAX_W-1:0] one;
        logic [FP_MAX_W-1:0] sgn;
        one    = '0;
        one[0] = 1'b1;
        sgn    = '0;
        sgn[0] = sign;
        return (((one << exp_w) - one) << man_w) | (sgn << (exp_w + man_w));
    endfunction

    // Canonical quiet NaN: positive, exponent all ones, only the fraction MSB set.
    function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        return fp_inf(exp_w, man_w, 1'b0) | (one << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_div_round.sv
// Normalise, round and range-check a raw quotient, then pack it with exception flags.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller holds inputs stable for as long as it samples the outputs.
module fp_div_round
    import fp_div_pkg::*;
#(
    parameter int  EXP_W = 8,
    parameter int  MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W,
    localparam int QW    = MAN_W + 4,
    localparam int EW2   = EXP_W + 2
) (
    input  logic                  sign,
    input  logic signed [EW2-1:0] exp_pre,
    input  logic [QW-1:0]         quo,
    input  logic                  sticky_in,
    input  fp_rm_t                rm,
    output logic [W-1:0]          result,
    output fp_flags_t             flags
);

    localparam logic [FP_MAX_W-1:0] INF_FULL = fp_inf(EXP_W, MAN_W, 1'b0);
    localparam logic [W-2:0]        INF_MAG  = INF_FULL[W-2:0];
    localparam logic [W-2:0]        MAX_MAG  = {{(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    localparam logic signed [EW2-1:0] EXP_LIM = EW2'((2**EXP_W) - 1);

    logic                  norm_shift;
    logic [MAN_W-1:0]      frac_raw;
    logic                  guard;
    logic                  rnd;
    logic                  sticky;
    logic                  inexact;
    logic                  inc;
    logic                  carry;
    logic [MAN_W-1:0]      frac;
    logic signed [EW2-1:0] exp_fin;
    logic                  ovf;
    logic                  unf;
    logic                  to_inf;

    // Quotient lies in (0.5, 2); a clear MSB means one extra bit of precision must be pulled up.
    assign norm_shift = ~quo[QW-1];
    assign frac_raw   = norm_shift ? quo[QW-3:2] : quo[QW-2:3];
    assign guard      = norm_shift ? quo[1] : quo[2];
    assign rnd        = norm_shift ? quo[0] : quo[1];
    assign sticky     = (norm_shift ? 1'b0 : quo[0]) | sticky_in;
    assign inexact    = guard | rnd | sticky;

    always_comb begin
        inc = 1'b0;
        case (rm)
            RM_RNE:  inc = guard & (rnd | sticky | frac_raw[0]);
            RM_RTZ:  inc = 1'b0;
            RM_RUP:  inc = inexact & ~sign;
            RM_RDN:  inc = inexact & sign;
            default: inc = 1'b0;
        endcase
    end

    // A fraction carry-out leaves the fraction at zero, i.e. significand 1.0 one binade up.
    assign {carry, frac} = {1'b0, frac_raw} + {{MAN_W{1'b0}}, inc};

    assign exp_fin = exp_pre
                   - $signed({{(EW2-1){1'b0}}, norm_shift})
                   + $signed({{(EW2-1){1'b0}}, carry});

    assign ovf    = exp_fin >= EXP_LIM;
    assign unf    = exp_fin[EW2-1] | (exp_fin == '0);
    assign to_inf = (rm == RM_RNE) | ((rm == RM_RUP) & ~sign) | ((rm == RM_RDN) & sign);

    always_comb begin
        flags         = '0;
        flags.inexact = inexact;
        result        = {sign, exp_fin[EXP_W-1:0], frac};
        if (ovf) begin
            flags.overflow = 1'b1;
            flags.inexact  = 1'b1;
            result         = to_inf ? {sign, INF_MAG} : {sign, MAX_MAG};
        end else if (unf) begin
            flags.underflow = 1'b1;
            flags.inexact   = 1'b1;
            result          = {sign, {(W-1){1'b0}}};
        end
    end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 divider: restoring division retiring BPC quotient bits per cycle.
// Latency: ceil((MAN_W+4)/BPC)+2 cycles accept-to-valid, 1 cycle for special operands.
// Backpressure: one op in flight; result held in DONE until out_ready, in_ready low while busy.
module fp_div_seq
    import fp_div_pkg::*;
#(
    parameter int  EXP_W = 8,
    parameter int  MAN_W = 23,
    parameter int  BPC   = 1,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   rm,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [4:0]   flags
);

    localparam int QW    = MAN_W + 4;
    localparam int NCYC  = (QW + BPC - 1) / BPC;
    localparam int NQ    = NCYC * BPC;
    localparam int CNT_W = $clog2(NCYC + 1);
    localparam int RW    = MAN_W + 2;
    localparam int EW2   = EXP_W + 2;
    localparam int BIAS  = (2**(EXP_W-1)) - 1;

    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(NCYC - 1);
    localparam logic [NQ-1:0]       LOW_MASK  = ~({NQ{1'b1}} << (NQ - QW));
    localparam logic [FP_MAX_W-1:0] INF_FULL  = fp_inf(EXP_W, MAN_W, 1'b0);
    localparam logic [FP_MAX_W-1:0] QNAN_FULL = fp_qnan(EXP_W, MAN_W);
    localparam logic [W-2:0]        INF_MAG   = INF_FULL[W-2:0];
    localparam logic [W-1:0]        QNAN      = QNAN_FULL[W-1:0];

    fp_div_state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q;
    logic             sign_q;
    logic [EXP_W-1:0] ea_q;
    logic [EXP_W-1:0] eb_q;
    logic [MAN_W:0]   div_q;
    logic [RW-1:0]    rem_q, rem_d;
    logic [NQ-1:0]    quo_q, quo_d;
    logic [RW:0]      diff;
    fp_rm_t           rm_q;
    logic [W-1:0]     result_q;
    fp_flags_t        flags_q;

    logic             a_sgn, b_sgn;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_frac, b_frac;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, q_sgn;
    logic             spec_hit;
    logic [W-1:0]     spec_res;
    fp_flags_t        spec_flg;

    logic signed [EW2-1:0] exp_pre;
    logic                  sticky_in;
    logic [W-1:0]          rnd_res;
    fp_flags_t             rnd_flg;

    assign {a_sgn, a_exp, a_frac} = a;
    assign {b_sgn, b_exp, b_frac} = b;

    // Denormal inputs are flushed: any zero exponent is treated as a zero operand.
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_nan  = (&a_exp) & (|a_frac);
    assign b_nan  = (&b_exp) & (|b_frac);
    assign a_inf  = (&a_exp) & ~(|a_frac);
    assign b_inf  = (&b_exp) & ~(|b_frac);
    assign q_sgn  = a_sgn ^ b_sgn;

    always_comb begin
        spec_hit = 1'b1;
        spec_res = '0;
        spec_flg = '0;
        if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
            spec_res         = QNAN;
            spec_flg.invalid = 1'b1;
        end else if (b_zero) begin
            spec_res             = {q_sgn, INF_MAG};
            spec_flg.div_by_zero = 1'b1;
        end else if (a_inf) begin
            spec_res = {q_sgn, INF_MAG};
        end else if (a_zero | b_inf) begin
            spec_res = {q_sgn, {(W-1){1'b0}}};
        end else begin
            spec_hit = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = spec_hit ? S_DONE : S_DIV;
            end
            S_DIV: begin
                if (cnt_q == CNT_LAST) state_d = S_RND;
            end
            S_RND: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Restoring steps: remainder stays below twice the divisor, so RW+1 bits expose the borrow.
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        diff  = '0;
        for (int k = 0; k < BPC; k++) begin
            diff  = {1'b0, rem_d} - {2'b00, div_q};
            quo_d = {quo_d[NQ-2:0], ~diff[RW]};
            if (!diff[RW]) rem_d = diff[RW-1:0];
            rem_d = rem_d << 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            ea_q     <= '0;
            eb_q     <= '0;
            div_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            rm_q     <= RM_RNE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        cnt_q  <= '0;
                        sign_q <= q_sgn;
                        ea_q   <= a_exp;
                        eb_q   <= b_exp;
                        div_q  <= {1'b1, b_frac};
                        rem_q  <= {2'b01, a_frac};
                        quo_q  <= '0;
                        rm_q   <= fp_rm_t'(rm);
                        if (spec_hit) begin
                            result_q <= spec_res;
                            flags_q  <= spec_flg;
                        end
                    end
                end
                S_DIV: begin
                    cnt_q <= cnt_q + 1'b1;
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                end
                S_RND: begin
                    result_q <= rnd_res;
                    flags_q  <= rnd_flg;
                end
                default: ;
            endcase
        end
    end

    assign exp_pre = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + $signed(EW2'(BIAS));

    // Quotient bits beyond QW (odd QW with BPC=2) only matter as sticky information.
    assign sticky_in = (|rem_q) | (|(quo_q & LOW_MASK));

    fp_div_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .sign      (sign_q),
        .exp_pre   (exp_pre),
        .quo       (quo_q[NQ-1 -: QW]),
        .sticky_in (sticky_in),
        .rm        (rm_q),
        .result    (rnd_res),
        .flags     (rnd_flg)
    );

    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Randomised and directed bench for fp_div_seq against an exact-arithmetic single-precision model.
module tb_fp_div_seq;

    localparam int BPC     = 1;
    localparam int NLAT    = (27 + BPC - 1) / BPC + 2;
    localparam int TIMEOUT = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [1:0]  rm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [4:0]  flags;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fp_div_seq #(.EXP_W(8), .MAN_W(23), .BPC(BPC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .rm        (rm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer quotient, rounding decided by comparing the discarded part to one half.
    task automatic ref_div(input logic [31:0] ra, input logic [31:0] rb, input logic [1:0] rrm,
                           output logic [31:0] res, output logic [4:0] fl, output logic spec);
        logic        sa, sb, s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic        inexact, above, tie, up, to_inf;
        logic [7:0]  ea, eb;
        logic [22:0] fa, fb;
        longint unsigned ma, mb, num, q, r, sig, rest, half;
        int          e, sh, carry;
        {sa, ea, fa} = ra;
        {sb, eb, fb} = rb;
        s      = sa ^ sb;
        a_nan  = (ea == 8'hFF) && (fa != 0);
        b_nan  = (eb == 8'hFF) && (fb != 0);
        a_inf  = (ea == 8'hFF) && (fa == 0);
        b_inf  = (eb == 8'hFF) && (fb == 0);
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        spec   = 1'b1;
        fl     = 5'b00000;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            res = 32'h7FC00000;
            fl  = 5'b10000;
        end else if (b_zero) begin
            res = {s, 8'hFF, 23'h0};
            fl  = 5'b01000;
        end else if (a_inf) begin
            res = {s, 8'hFF, 23'h0};
        end else if (a_zero || b_inf) begin
            res = {s, 31'h0};
        end else begin
            spec = 1'b0;
            ma   = 64'({1'b1, fa});
            mb   = 64'({1'b1, fb});
            num  = ma << 27;
            q    = num / mb;
            r    = num % mb;
            if (q >= (64'd1 << 27)) begin
                sh = 0; sig = q >> 4; rest = q & 64'd15; half = 64'd8;
            end else begin
                sh = 1; sig = q >> 3; rest = q & 64'd7;  half = 64'd4;
            end
            inexact = (rest != 0) || (r != 0);
            above   = (rest > half) || ((rest == half) && (r != 0));
            tie     = (rest == half) && (r == 0);
            case (rrm)
                2'd0:    up = above || (tie && ((sig & 64'd1) != 0));
                2'd1:    up = 1'b0;
                2'd2:    up = inexact && !s;
                default: up = inexact && s;
            endcase
            sig   = sig + 64'(up);
            carry = 0;
            if (sig == (64'd1 << 24)) begin
                sig   = 64'd1 << 23;
                carry = 1;
            end
            e = int'(ea) - int'(eb) + 127 - sh + carry;
            if (e >= 255) begin
                to_inf = (rrm == 2'd0) || ((rrm == 2'd2) && !s) || ((rrm == 2'd3) && s);
                res    = to_inf ? {s, 8'hFF, 23'h0} : {s, 8'hFE, 23'h7FFFFF};
                fl     = 5'b00101;
            end else if (e <= 0) begin
                res = {s, 31'h0};
                fl  = 5'b00011;
            end else begin
                res = {s, e[7:0], 23'(sig)};
                fl  = {4'b0000, inexact};
            end
        end
    endtask

    // One full transaction; operands are scrambled while busy to show they are registered at accept.
    task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b, input logic [1:0] op_rm,
                          input int hold, output logic [31:0] got_res, output logic [4:0] got_fl,
                          output int lat);
        int busy_bad;
        int stall_bad;
        @(negedge clk);
        chk("accept_rdy", 64'(in_ready), 64'(1));
        a = op_a; b = op_b; rm = op_rm; in_valid = 1'b1;
        @(posedge clk); #1;
        lat      = 0;
        busy_bad = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (out_valid || lat > TIMEOUT) break;
            if (in_ready) busy_bad++;
            in_valid = 1'($urandom_range(0, 1));
            a  = $urandom;
            b  = $urandom;
            rm = 2'($urandom);
        end
        in_valid = 1'b0;
        chk("busy_rdy", 64'(busy_bad), 64'(0));
        chk("out_valid_seen", 64'(out_valid), 64'(1));
        got_res = result;
        got_fl  = flags;
        if (!out_valid) return;
        stall_bad = 0;
        repeat (hold) begin
            @(negedge clk);
            if (!out_valid || in_ready || result !== got_res || flags !== got_fl) stall_bad++;
        end
        if (hold > 0) chk("stall_hold", 64'(stall_bad), 64'(0));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("idle_after", 64'({in_ready, out_valid}), 64'(2'b10));
    endtask

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  rm;
        logic [31:0] res;
        logic [4:0]  fl;
        logic        spec;
    } vec_t;

    vec_t vecs [0:16] = '{
        '{32'h40C00000, 32'h40000000, 2'd0, 32'h40400000, 5'b00000, 1'b0},
        '{32'h3F800000, 32'h40400000, 2'd0, 32'h3EAAAAAB, 5'b00001, 1'b0},
        '{32'h3F800000, 32'h40400000, 2'd1, 32'h3EAAAAAA, 5'b00001, 1'b0},
        '{32'h3F800000, 32'h40400000, 2'd2, 32'h3EAAAAAB, 5'b00001, 1'b0},
        '{32'hBF800000, 32'h40400000, 2'd3, 32'hBEAAAAAB, 5'b00001, 1'b0},
        '{32'hBF800000, 32'h40400000, 2'd2, 32'hBEAAAAAA, 5'b00001, 1'b0},
        '{32'h3F800000, 32'h00000000, 2'd0, 32'h7F800000, 5'b01000, 1'b1},
        '{32'h00000000, 32'h80000000, 2'd0, 32'h7FC00000, 5'b10000, 1'b1},
        '{32'h7F000000, 32'h3E800000, 2'd0, 32'h7F800000, 5'b00101, 1'b0},
        '{32'h7F000000, 32'h3E800000, 2'd1, 32'h7F7FFFFF, 5'b00101, 1'b0},
        '{32'hFF000000, 32'h3E800000, 2'd2, 32'hFF7FFFFF, 5'b00101, 1'b0},
        '{32'h00800000, 32'h40000000, 2'd0, 32'h00000000, 5'b00011, 1'b0},
        '{32'h7FC00001, 32'h3F800000, 2'd0, 32'h7FC00000, 5'b10000, 1'b1},
        '{32'hFF800000, 32'h3F800000, 2'd0, 32'hFF800000, 5'b00000, 1'b1},
        '{32'h3F800000, 32'hFF800000, 2'd0, 32'h80000000, 5'b00000, 1'b1},
        '{32'h7F800000, 32'h7F800000, 2'd0, 32'h7FC00000, 5'b10000, 1'b1},
        '{32'h00400000, 32'h3F800000, 2'd0, 32'h00000000, 5'b00000, 1'b1}
    };

    function automatic logic [31:0] rand_fp();
        logic [7:0]  e;
        logic [22:0] f;
        f = 23'($urandom);
        if ($urandom_range(0, 7) == 0) f = '0;
        case ($urandom_range(0, 15))
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2, 3:    e = 8'($urandom_range(1, 254));
            default: e = 8'($urandom_range(110, 144));
        endcase
        return {1'($urandom), e, f};
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got_res, exp_res, ra, rb;
        logic [4:0]  got_fl, exp_fl;
        logic [1:0]  rrm;
        logic        spec;
        int          lat, bad, hold;

        repeat (3) @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),  64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_result",    64'(result),    64'(0));
        chk("rst_flags",     64'(flags),     64'(0));
        rst_n = 1'b1;

        for (int i = 0; i < $size(vecs); i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].rm, 0, got_res, got_fl, lat);
            chk($sformatf("vec%0d_res", i), 64'(got_res), 64'(vecs[i].res));
            chk($sformatf("vec%0d_flags", i), 64'(got_fl), 64'(vecs[i].fl));
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].spec ? 1 : NLAT));
        end

        run_op(32'h40C00000, 32'h40000000, 2'd0, 10, got_res, got_fl, lat);
        chk("stall_res", 64'(got_res), 64'(32'h40400000));

        // Reset pulsed part-way through a division must discard it without any output.
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40400000; rm = 2'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_async", 64'({in_ready, out_valid}), 64'(2'b10));
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid || !in_ready) bad++;
        end
        chk("rst_mid_quiet",  64'(bad),    64'(0));
        chk("rst_mid_result", 64'(result), 64'(0));
        chk("rst_mid_flags",  64'(flags),  64'(0));

        for (int i = 0; i < 300; i++) begin
            ra   = rand_fp();
            rb   = rand_fp();
            rrm  = 2'($urandom);
            hold = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0;
            ref_div(ra, rb, rrm, exp_res, exp_fl, spec);
            run_op(ra, rb, rrm, hold, got_res, got_fl, lat);
            chk($sformatf("rnd%0d_res a=%h b=%h rm=%0d", i, ra, rb, rrm), 64'(got_res), 64'(exp_res));
            chk($sformatf("rnd%0d_flags", i), 64'(got_fl), 64'(exp_fl));
            chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'(spec ? 1 : NLAT));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
